psx_pad_responder: RTL

PSX_PAD_RESPONDER -- requirements
Module: psx_pad_responder

---
 rtl/psx_pad_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/psx_pad_responder.sv
// psx_pad_responder: PlayStation digital pad emulator answering the host's 5-byte poll
// over an asynchronous SPI-like link, with delayed/timed acknowledge pulses.
module psx_pad_responder #(
   parameter int ACK_DELAY = 100,
   parameter int ACK_WIDTH = 50
) (
   input  logic        Clk,
   input  logic        sys_reset,
   input  logic [15:0] buttons_n,
   input  logic        psSEL_n,
   input  logic        psCLK,
   input  logic        psTXD,
   output logic        psRXD,
   output logic        psRXD_oe,
   output logic        psACK_n,
   output logic [7:0]  cmd_byte,
   output logic        poll_done
);
   localparam int ACK_END = ACK_DELAY + ACK_WIDTH;
   localparam int CW = $clog2(ACK_END + 1);
   localparam logic [CW-1:0] ACK_LO = CW'(ACK_DELAY);
   localparam logic [CW-1:0] ACK_HI = CW'(ACK_END);
   typedef enum logic [2:0] {IDLE, B0, B1, B2, B3, B4, IGNORE} state_t;
   state_t state, nxt;
   logic [1:0] sel_s, clk_s, txd_s, warm;
   logic sel_d, clk_d, rxd;
   logic [2:0] bit_cnt;
   logic [7:0] rx_sh, tx_sh, rx_byte, resp;
   logic [15:0] btn;
   logic [CW-1:0] ack_cnt, ack_nxt;
   logic active, nxt_active, sel_fall, sel_rise, clk_rise, clk_fall, byte_done, ok, ack_go, poll_go;
   assign active = state inside {B0, B1, B2, B3, B4};
   assign nxt_active = nxt inside {B0, B1, B2, B3, B4};
   assign sel_rise = ~sel_d & sel_s[1];
   // Falls seen while the synchronizers are still leaving their reset value are not real selects.
   assign sel_fall = (warm == 2'd3) & sel_d & ~sel_s[1];
   assign clk_rise = ~clk_d & clk_s[1];
   assign clk_fall = clk_d & ~clk_s[1];
   assign byte_done = active & clk_rise & (bit_cnt == 3'd7);
   assign rx_byte = {txd_s[1], rx_sh[7:1]};
   assign psRXD_oe = active;
   assign psRXD = ~active | rxd;
   always_comb begin
      nxt = state;
      ok = 1'b0;
      ack_go = 1'b0;
      poll_go = 1'b0;
      if (sel_rise)
         nxt = IDLE;
      else if (state == IDLE && sel_fall)
         nxt = B0;
      else if (byte_done) begin
         ok = state == B0 ? rx_byte == 8'h01 : state == B1 ? rx_byte == 8'h42 : 1'b1;
         nxt = ok ? state_t'(3'(state + 3'd1)) : IGNORE;
         ack_go = ok & (state != B4);
         poll_go = state == B4;
      end
      resp = nxt == B0 ? 8'hFF : nxt == B1 ? 8'h41 : nxt == B2 ? 8'h5A :
             nxt == B3 ? btn[7:0] : btn[15:8];
      ack_nxt = sel_rise ? '0 : ack_go ? CW'(1) :
                (ack_cnt == '0 || ack_cnt == ACK_HI) ? '0 : ack_cnt + CW'(1);
   end
   always_ff @(posedge Clk) begin
      if (sys_reset) begin
         state <= IDLE;
         sel_s <= 2'b11;
         clk_s <= 2'b11;
         txd_s <= 2'b11;
         sel_d <= 1'b1;
         clk_d <= 1'b1;
         warm <= 2'd0;
         bit_cnt <= 3'd0;
         rx_sh <= 8'h00;
         tx_sh <= 8'hFF;
         btn <= 16'h0000;
         rxd <= 1'b1;
         ack_cnt <= '0;
         psACK_n <= 1'b1;
         cmd_byte <= 8'h00;
         poll_done <= 1'b0;
      end else begin
         state <= nxt;
         sel_s <= {sel_s[0], psSEL_n};
         clk_s <= {clk_s[0], psCLK};
         txd_s <= {txd_s[0], psTXD};
         sel_d <= sel_s[1];
         clk_d <= clk_s[1];
         if (warm != 2'd3)
            warm <= warm + 2'd1;
         ack_cnt <= ack_nxt;
         psACK_n <= ~(ack_nxt > ACK_LO && ack_nxt <= ACK_HI);
         poll_done <= poll_go;
         if (byte_done && !sel_rise)
            cmd_byte <= rx_byte;
         if (!active || sel_rise)
            bit_cnt <= 3'd0;
         else if (clk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sh <= rx_byte;
         end
         if (state == IDLE && nxt == B0)
            btn <= buttons_n;
         // New response byte on every state entry; psRXD stays high until the host's first falling edge.
         if (nxt != state && nxt_active) begin
            tx_sh <= resp;
            rxd <= 1'b1;
         end else if (active && clk_fall) begin
            rxd <= tx_sh[0];
            tx_sh <= {1'b1, tx_sh[7:1]};
         end
      end
   end
endmodule
